// File: rtl/cfgreg_rstctl_pkg.sv
// Shared constants and types for the CPU-subsystem reset/config register block.
package cfgreg_pkg;

  localparam logic [11:0] CFGREG_RSTN         = 12'h000;
  localparam logic [11:0] CFGREG_PULSE        = 12'h004;
  localparam logic [11:0] CFGREG_STATUS       = 12'h008;
  localparam logic [11:0] CFGREG_ID           = 12'h00C;
  localparam logic [11:0] CFGREG_SCRATCH_BASE = 12'h100;

  localparam logic [15:0] CFGREG_ID_UPPER = 16'h0002;

  typedef enum logic [1:0] {
    OFF,
    HOLD,
    RUN
  } rst_state_e;

endpackage

// File: rtl/cfgreg_rstctl_if.sv
// APB3/4-style slave bus bundle for cfgreg_rstctl.
interface cfgreg_rstctl_if;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pslverr;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pstrb, pwdata,
    input  prdata, pslverr, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pstrb, pwdata,
    output prdata, pslverr, pready
  );

endinterface

// File: rtl/cfgreg_rstctl_rstseq.sv
// Single-core reset sequencer: OFF/HOLD/RUN FSM with a minimum-hold down-counter.
module cfgreg_rstseq
  import cfgreg_pkg::*;
#(
  parameter int unsigned RST_HOLD = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic rel_wr,
  input  logic rel_val,
  input  logic pulse,
  output logic rstn,
  output logic busy
);

  localparam int unsigned    CW     = $clog2(RST_HOLD);
  localparam logic [CW-1:0]  RELOAD = CW'(RST_HOLD - 1);

  rst_state_e    state;
  logic [CW-1:0] cnt;

  // rstn is updated alongside the state so it is high exactly while in RUN
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= OFF;
      cnt   <= '0;
      rstn  <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (rel_wr && rel_val) begin
            state <= HOLD;
            cnt   <= RELOAD;
          end
        end
        HOLD: begin
          if (rel_wr && !rel_val) begin
            state <= OFF;
            cnt   <= '0;
          end else if (pulse) begin
            cnt <= RELOAD;
          end else if (cnt == '0) begin
            state <= RUN;
            rstn  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (rel_wr && !rel_val) begin
            state <= OFF;
            rstn  <= 1'b0;
          end else if (pulse) begin
            state <= HOLD;
            cnt   <= RELOAD;
            rstn  <= 1'b0;
          end
        end
        default: begin
          state <= OFF;
          cnt   <= '0;
          rstn  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == HOLD);

endmodule

// File: rtl/cfgreg_rstctl.sv
// APB config/reset-control slave: per-core reset sequencers, pulses, status/ID, scratch.
// Optional slave-error reporting enabled by defining CFGREG_SLVERR_EN.
module cfgreg_rstctl
  import cfgreg_pkg::*;
#(
  parameter int unsigned NCORE    = 2,
  parameter int unsigned NSCRATCH = 4,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  cfgreg_rstctl_if.slave   apb,
  output logic [NCORE-1:0] core_rstn
);

  logic [11:0]      addr;
  logic             wr, rd;
  logic             hit_rstn, hit_pulse, hit_status, hit_id, hit_scr;
  logic             rel_wr, pulse_wr;
  logic [NCORE-1:0] busy;
  logic [31:0]      rdata;
  logic [31:0]      prdata_q;
  logic [31:0]      scratch [NSCRATCH];
  logic             unused_paddr;

  assign addr         = apb.paddr[11:0];
  assign unused_paddr = ^apb.paddr[31:12];

  assign wr = apb.psel & ~apb.penable &  apb.pwrite;
  assign rd = apb.psel & ~apb.penable & ~apb.pwrite;

  assign hit_rstn   = (addr == CFGREG_RSTN);
  assign hit_pulse  = (addr == CFGREG_PULSE);
  assign hit_status = (addr == CFGREG_STATUS);
  assign hit_id     = (addr == CFGREG_ID);
  assign hit_scr    = (addr[11:8] == CFGREG_SCRATCH_BASE[11:8]) && (addr[1:0] == 2'b00)
                      && (32'(addr[7:2]) < NSCRATCH);

  assign rel_wr   = wr & hit_rstn  & apb.pstrb[0];
  assign pulse_wr = wr & hit_pulse & apb.pstrb[0];

  for (genvar g = 0; g < NCORE; g++) begin : g_seq
    cfgreg_rstseq #(.RST_HOLD(RST_HOLD)) u_seq (
      .pclk    (pclk),
      .presetn (presetn),
      .rel_wr  (rel_wr),
      .rel_val (apb.pwdata[g]),
      .pulse   (pulse_wr & apb.pwdata[g]),
      .rstn    (core_rstn[g]),
      .busy    (busy[g])
    );
  end

  always_comb begin
    rdata = '0;
    if (hit_rstn)   rdata = 32'(core_rstn);
    if (hit_status) rdata = 32'(busy);
    if (hit_id)     rdata = {CFGREG_ID_UPPER, 8'(NSCRATCH), 8'(NCORE)};
    for (int unsigned i = 0; i < NSCRATCH; i++) begin
      if (hit_scr && (addr[7:2] == 6'(i))) rdata = scratch[i];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata_q <= '0;
    end else if (rd) begin
      prdata_q <= rdata;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < NSCRATCH; i++) scratch[i] <= '0;
    end else if (wr && hit_scr) begin
      for (int unsigned i = 0; i < NSCRATCH; i++) begin
        if (addr[7:2] == 6'(i)) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (apb.pstrb[b]) scratch[i][8*b +: 8] <= apb.pwdata[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef CFGREG_SLVERR_EN
  logic err;
  logic pslverr_q;

  // Erroring accesses already have no side effect and read 0 through the decode above
  assign err = ~(hit_rstn | hit_pulse | hit_status | hit_id | hit_scr)
             | (wr & (hit_status | hit_id))
             | (rd & hit_pulse);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pslverr_q <= 1'b0;
    end else begin
      pslverr_q <= (wr | rd) & err;
    end
  end

  assign apb.pslverr = pslverr_q;
`else
  assign apb.pslverr = 1'b0;
`endif

  assign apb.prdata = prdata_q;
  assign apb.pready = 1'b1;

endmodule

// File: tb/tb_cfgreg_rstctl.sv
// Scoreboard bench for cfgreg_rstctl (NCORE=2, NSCRATCH=4, RST_HOLD=16).
module tb_cfgreg_rstctl;

`ifdef CFGREG_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  typedef struct {
    string       nm;
    bit          chk_d;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic [1:0] core_rstn;
  int         cyc = 0;
  int         e0 = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       sb[$];
  exp_t       x;

  cfgreg_rstctl_if ifc ();

  cfgreg_rstctl #(.NCORE(2), .NSCRATCH(4), .RST_HOLD(16)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (ifc.slave),
    .core_rstn (core_rstn)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: every access phase pops one expectation
  always @(negedge pclk) begin
    if (presetn && ifc.psel && ifc.penable) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_access: no expectation queued at addr %h", ifc.paddr);
      end else begin
        x = sb.pop_front();
        if (x.chk_d) begin
          n_cmp++;
          if (ifc.prdata !== x.d) begin
            n_bad++;
            $display("FAIL %s prdata: got %h want %h", x.nm, ifc.prdata, x.d);
          end
        end
        n_cmp++;
        if (ifc.pslverr !== x.e || ifc.pready !== 1'b1) begin
          n_bad++;
          $display("FAIL %s pslverr/pready: got %b/%b want %b/1", x.nm, ifc.pslverr, ifc.pready, x.e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge pclk); #1;
    end
  endtask

  // Called just after a posedge; setup now, E0 at the next edge.
  task automatic apb_wr(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit err);
    sb.push_back('{nm: nm, chk_d: 1'b0, d: 32'h0, e: err});
    ifc.psel = 1'b1; ifc.penable = 1'b0; ifc.pwrite = 1'b1;
    ifc.paddr = a; ifc.pwdata = d; ifc.pstrb = s;
    @(posedge pclk); #1;
    e0 = cyc;
    ifc.penable = 1'b1;
    @(posedge pclk); #1;
    ifc.psel = 1'b0; ifc.penable = 1'b0; ifc.pwrite = 1'b0;
  endtask

  task automatic apb_rd(input string nm, input logic [31:0] a, input logic [31:0] d, input bit err);
    sb.push_back('{nm: nm, chk_d: 1'b1, d: d, e: err});
    ifc.psel = 1'b1; ifc.penable = 1'b0; ifc.pwrite = 1'b0;
    ifc.paddr = a; ifc.pstrb = 4'h0;
    @(posedge pclk); #1;
    ifc.penable = 1'b1;
    @(posedge pclk); #1;
    ifc.psel = 1'b0; ifc.penable = 1'b0;
  endtask

  int p0, a0, r0;

  initial begin
    ifc.psel = 1'b0; ifc.penable = 1'b0; ifc.pwrite = 1'b0;
    ifc.paddr = '0; ifc.pwdata = '0; ifc.pstrb = '0;
    #1;
    chk("reset_core_rstn", 32'(core_rstn), 32'h0);
    chk("reset_prdata", ifc.prdata, 32'h0);
    chk("reset_pslverr", 32'(ifc.pslverr), 32'h0);
    wait_edge(3);
    presetn = 1'b1;
    @(posedge pclk); #1;

    apb_rd("id", 32'h00C, 32'h0002_0402, 1'b0);
    apb_rd("rstn_after_reset", 32'h000, 32'h0, 1'b0);
    apb_rd("status_after_reset", 32'h008, 32'h0, 1'b0);

    // Release both cores; hold is exactly 16 cycles
    apb_wr("rel_both", 32'h000, 32'h3, 4'hF, 1'b0);
    p0 = e0;
    apb_rd("rstn_pre_release", 32'h000, 32'h0, 1'b0);
    apb_rd("status_hold", 32'h008, 32'h3, 1'b0);
    wait_edge(p0 + 15);
    chk("core_rstn_at_e0p15", 32'(core_rstn), 32'h0);
    wait_edge(p0 + 16);
    chk("core_rstn_at_e0p16", 32'(core_rstn), 32'h3);
    apb_rd("rstn_run", 32'h000, 32'h3, 1'b0);
    apb_rd("status_run", 32'h008, 32'h0, 1'b0);

    // Single pulse on core 0
    apb_wr("pulse0", 32'h004, 32'h1, 4'h1, 1'b0);
    p0 = e0;
    chk("pulse_fall", 32'(core_rstn), 32'h2);
    wait_edge(p0 + 15);
    chk("pulse_p15", 32'(core_rstn), 32'h2);
    wait_edge(p0 + 16);
    chk("pulse_p16", 32'(core_rstn), 32'h3);

    // Second pulse lands 10 cycles into the hold: 26 cycles low
    apb_wr("pulse0_a", 32'h004, 32'h1, 4'hF, 1'b0);
    p0 = e0;
    wait_edge(p0 + 9);
    apb_wr("pulse0_b", 32'h004, 32'h1, 4'hF, 1'b0);
    chk("pulse_b_e0", e0, p0 + 10);
    wait_edge(p0 + 16);
    chk("dbl_pulse_p16", 32'(core_rstn), 32'h2);
    wait_edge(p0 + 25);
    chk("dbl_pulse_p25", 32'(core_rstn), 32'h2);
    wait_edge(p0 + 26);
    chk("dbl_pulse_p26", 32'(core_rstn), 32'h3);

    // Turn all off; pulses to OFF cores are ignored
    apb_wr("all_off", 32'h000, 32'h0, 4'h1, 1'b0);
    chk("all_off_rstn", 32'(core_rstn), 32'h0);
    apb_wr("pulse_off", 32'h004, 32'h3, 4'h1, 1'b0);
    apb_rd("status_pulse_off", 32'h008, 32'h0, 1'b0);

    // Abort mid-hold
    apb_wr("abort_rel", 32'h000, 32'h1, 4'h1, 1'b0);
    a0 = e0;
    wait_edge(a0 + 4);
    apb_wr("abort_off", 32'h000, 32'h0, 4'h1, 1'b0);
    apb_rd("status_abort", 32'h008, 32'h0, 1'b0);
    wait_edge(a0 + 16);
    chk("abort_p16", 32'(core_rstn), 32'h0);
    wait_edge(a0 + 20);
    chk("abort_p20", 32'(core_rstn), 32'h0);

    // Strobe-gated RSTN write is ignored
    apb_wr("rstn_nostrb", 32'h000, 32'h3, 4'hE, 1'b0);
    apb_rd("status_nostrb", 32'h008, 32'h0, 1'b0);

    // Scratch byte strobes and last index
    apb_wr("scr1_wr", 32'h104, 32'hDEAD_BEEF, 4'b0101, 1'b0);
    apb_rd("scr1_rd", 32'h104, 32'h00AD_00EF, 1'b0);
    apb_rd("scr0_rd", 32'h100, 32'h0, 1'b0);
    apb_wr("scr3_wr", 32'h10C, 32'h1234_5678, 4'hF, 1'b0);
    apb_rd("scr3_rd", 32'h10C, 32'h1234_5678, 1'b0);
    apb_wr("scr3_hi", 32'h10C, 32'hAB00_0000, 4'b1000, 1'b0);
    apb_rd("scr3_rd2", 32'h10C, 32'hAB34_5678, 1'b0);
    apb_rd("scr4_unmapped", 32'h110, 32'h0, SLV);

    // Error cases
    apb_rd("unmapped_0fc", 32'h0FC, 32'h0, SLV);
    apb_rd("misaligned", 32'h002, 32'h0, SLV);
    apb_rd("pulse_rd", 32'h004, 32'h0, SLV);
    apb_wr("id_wr", 32'h00C, 32'hFFFF_FFFF, 4'hF, SLV);
    apb_wr("status_wr", 32'h008, 32'hFFFF_FFFF, 4'hF, SLV);
    apb_wr("unmapped_wr", 32'h0F0, 32'hFFFF_FFFF, 4'hF, SLV);
    apb_rd("id_after_wr", 32'h00C, 32'h0002_0402, 1'b0);
    apb_rd("status_after_wr", 32'h008, 32'h0, 1'b0);

    // Async reset mid-hold
    apb_wr("rel_for_reset", 32'h000, 32'h3, 4'h1, 1'b0);
    r0 = e0;
    apb_rd("id_before_reset", 32'h00C, 32'h0002_0402, 1'b0);
    wait_edge(r0 + 5);
    #2;
    presetn = 1'b0;
    #1;
    chk("midhold_rst_core_rstn", 32'(core_rstn), 32'h0);
    chk("midhold_rst_prdata", ifc.prdata, 32'h0);
    chk("midhold_rst_pslverr", 32'(ifc.pslverr), 32'h0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    apb_rd("status_post_reset", 32'h008, 32'h0, 1'b0);
    apb_rd("scr1_post_reset", 32'h104, 32'h0, 1'b0);
    wait_edge(r0 + 20);
    chk("post_reset_core_rstn", 32'(core_rstn), 32'h0);

    repeat (3) @(posedge pclk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
